shift_register_8b: RTL and testbench



---
 rtl/shift_register_8b.sv | 53 +++++
 tb/tb_shift_register_8b.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/shift_register_8b.sv
// Right-shift register with parallel load, serial in and a registered serial out.
// Optional macro SR_ROTATE_EN adds a rotate input that wraps the LSB into the MSB.
module shift_register_8b #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] parallelIn,
  input  logic             serialIn,
  input  logic             mode,
`ifdef SR_ROTATE_EN
  input  logic             rotate,
`endif
  output logic             serialOut,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] state_q, state_d;
  logic             sout_q, sout_d;
  logic             fill_bit;

  // Bit entering the MSB on a shift: serialIn, or the outgoing LSB when rotating.
`ifdef SR_ROTATE_EN
  assign fill_bit = rotate ? state_q[0] : serialIn;
`else
  assign fill_bit = serialIn;
`endif

  always_comb begin
    state_d = state_q;
    sout_d  = sout_q;
    if (mode) begin
      state_d = parallelIn;
    end else begin
      sout_d  = state_q[0];
      state_d = {fill_bit, state_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= '0;
      sout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sout_q  <= sout_d;
    end
  end

  assign state     = state_q;
  assign serialOut = sout_q;

endmodule

// File: tb/tb_shift_register_8b.sv
// Self-checking bench for shift_register_8b: directed plan sequences plus random
// traffic compared against an arithmetic reference model.
module tb_shift_register_8b;

  localparam int unsigned W = 8;

  logic         clk;
  logic         reset;
  logic [W-1:0] parallelIn;
  logic         serialIn;
  logic         mode;
  logic         rotate;
  logic         serialOut;
  logic [W-1:0] state;

  int unsigned n_total;
  int unsigned n_bad;

  // Reference model state
  longint unsigned ref_state;
  logic            ref_sout;

  shift_register_8b #(
    .WIDTH(W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .parallelIn(parallelIn),
    .serialIn  (serialIn),
    .mode      (mode),
`ifdef SR_ROTATE_EN
    .rotate    (rotate),
`endif
    .serialOut (serialOut),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one operation, advance one edge, update the model and compare.
  task automatic apply(input logic r, input logic m, input logic [W-1:0] p, input logic s,
                       input logic rot);
    logic in_bit;
    reset      = r;
    mode       = m;
    parallelIn = p;
    serialIn   = s;
    rotate     = rot;
    @(posedge clk);
    if (r) begin
      ref_state = 0;
      ref_sout  = 1'b0;
    end else if (m) begin
      ref_state = longint'(p);
    end else begin
`ifdef SR_ROTATE_EN
      in_bit = rot ? ref_state[0] : s;
`else
      in_bit = s;
`endif
      ref_sout  = ref_state[0];
      ref_state = ref_state / 2 + (in_bit ? (64'd1 << (W - 1)) : 64'd0);
    end
    #1;
    check_eq("model_state", {56'd0, state}, ref_state);
    check_eq("model_sout", {63'd0, serialOut}, {63'd0, ref_sout});
  endtask

  logic [7:0] exp_st[6];
  logic       exp_so[6];
  logic [7:0] tmp;

  initial begin
    n_total    = 0;
    n_bad      = 0;
    ref_state  = 0;
    ref_sout   = 1'b0;
    reset      = 1'b1;
    mode       = 1'b0;
    parallelIn = '0;
    serialIn   = 1'b0;
    rotate     = 1'b0;

    // Reset, load 0x09, shift with serialIn=0
    apply(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check_eq("reset_state", {56'd0, state}, 64'h0);
    check_eq("reset_sout", {63'd0, serialOut}, 64'h0);
    apply(1'b0, 1'b1, 8'h09, 1'b0, 1'b0);
    check_eq("load09_state", {56'd0, state}, 64'h09);
    exp_st = '{8'h04, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00};
    exp_so = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      check_eq($sformatf("t1_state%0d", i), {56'd0, state}, {56'd0, exp_st[i]});
      check_eq($sformatf("t1_sout%0d", i), {63'd0, serialOut}, {63'd0, exp_so[i]});
    end

    // Reset mid-shift, then load 0x1C and shift
    apply(1'b0, 1'b1, 8'hB7, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    apply(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    apply(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("midreset_state", {56'd0, state}, 64'h0);
    check_eq("midreset_sout", {63'd0, serialOut}, 64'h0);
    apply(1'b0, 1'b1, 8'h1C, 1'b0, 1'b0);
    exp_st = '{8'h0E, 8'h07, 8'h03, 8'h01, 8'h00, 8'h00};
    exp_so = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      check_eq($sformatf("t2_state%0d", i), {56'd0, state}, {56'd0, exp_st[i]});
      check_eq($sformatf("t2_sout%0d", i), {63'd0, serialOut}, {63'd0, exp_so[i]});
    end

    // From zero, shift ones in for W cycles
    tmp = 8'h00;
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      tmp = {1'b1, tmp[7:1]};
      check_eq($sformatf("t3_state%0d", i), {56'd0, state}, {56'd0, tmp});
      check_eq($sformatf("t3_sout%0d", i), {63'd0, serialOut}, 64'h0);
    end
    check_eq("t3_allones", {56'd0, state}, 64'hFF);

    // Reset beats load
    apply(1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check_eq("pre_rst_sout", {63'd0, serialOut}, 64'h1);
    apply(1'b1, 1'b1, 8'hA5, 1'b1, 1'b0);
    check_eq("rstprio_state", {56'd0, state}, 64'h0);
    check_eq("rstprio_sout", {63'd0, serialOut}, 64'h0);

    // Load holds serialOut
    apply(1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check_eq("hold_pre", {63'd0, serialOut}, 64'h1);
    apply(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    check_eq("hold_sout", {63'd0, serialOut}, 64'h1);
    check_eq("hold_state", {56'd0, state}, 64'h0);
    apply(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check_eq("hold_after_shift", {63'd0, serialOut}, 64'h0);

`ifdef SR_ROTATE_EN
    apply(1'b0, 1'b1, 8'h81, 1'b0, 1'b0);
    exp_st = '{8'hC0, 8'h60, 8'h30, 8'h00, 8'h00, 8'h00};
    exp_so = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      check_eq($sformatf("rot_state%0d", i), {56'd0, state}, {56'd0, exp_st[i]});
      check_eq($sformatf("rot_sout%0d", i), {63'd0, serialOut}, {63'd0, exp_so[i]});
    end
`endif

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 3),
            W'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
